// File: rtl/uart_receiver_if.sv
// Bundle of serial-side inputs and word-side outputs of the UART receiver.
// The master side drives the line and the 16x baud tick; the slave side is the
// receiver, which returns the framed word and its status pulses.
interface uart_receiver_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] rx_dout;
    logic            rx_done_tick;
    logic            parity_err;
    logic            frame_err;

    modport master (
        output rx,
        output s_tick,
        input  rx_dout,
        input  rx_done_tick,
        input  parity_err,
        input  frame_err
    );

    modport slave (
        input  rx,
        input  s_tick,
        output rx_dout,
        output rx_done_tick,
        output parity_err,
        output frame_err
    );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: samples the start bit at its middle, then every
// data/parity/stop bit 16 ticks later, with optional parity and a break state
// so that a line held low reports only a single framing error.
module uart_receiver #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PAR_EN  = 0,
    parameter int PAR_ODD = 0
) (
    input  logic           clk,
    input  logic           reset,
    uart_receiver_if.slave bus
);

    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID     = SW'(7);
    localparam logic [SW-1:0] S_LAST    = SW'(15);
    localparam logic [SW-1:0] S_STOP    = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
    localparam logic          PAR_EN_B  = (PAR_EN != 0);
    localparam logic          PAR_ODD_B = (PAR_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    logic            rx_meta_q;
    logic            rx_sync_q;

    state_t          state_q,  state_d;
    logic [SW-1:0]   s_q,      s_d;
    logic [NW-1:0]   n_q,      n_d;
    logic [DBIT-1:0] b_q,      b_d;
    logic            p_err_q,  p_err_d;
    logic [DBIT-1:0] dout_q,   dout_d;
    logic            done_q,   done_d;
    logic            perr_q,   perr_d;
    logic            ferr_q,   ferr_d;

    logic [DBIT:0]   shift_in;

    // Two-flop synchronizer; resets to the idle-high line level so no false start is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // State, counters, shift register and registered output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_err_q <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_err_q <= p_err_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // New bit enters at the MSB so that after DBIT samples the LSB-first word is aligned.
    assign shift_in = {rx_sync_q, b_q};

    // Next-state and pulse decisions; pulses are computed here and appear one clk after the deciding tick.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_err_d = p_err_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end

            START: begin
                if (bus.s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_sync_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            DATA: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = shift_in[DBIT:1];
                        if (n_q == N_LAST) begin
                            state_d = PAR_EN_B ? PARITY : STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            PARITY: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        p_err_d = rx_sync_q ^ (^b_q) ^ PAR_ODD_B;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            STOP: begin
                if (bus.s_tick) begin
                    if (s_q == S_STOP) begin
                        s_d = '0;
                        if (rx_sync_q) begin
                            dout_d  = b_q;
                            done_d  = 1'b1;
                            perr_d  = p_err_q & PAR_EN_B;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            BREAK: begin
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rx_dout      = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.parity_err   = perr_q;
    assign bus.frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: one default instance (no parity) and one
// even-parity instance share the clock, reset and 16x tick; each has its own line.
module tb_uart_receiver;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic s_tick = 1'b0;
    logic rx_a   = 1'b1;
    logic rx_b   = 1'b1;

    int total = 0;
    int bad   = 0;

    int a_done_cnt       = 0;
    int a_ferr_cnt       = 0;
    int a_perr_cnt       = 0;
    int a_wide           = 0;
    int b_done_cnt       = 0;
    int b_perr_with_done = 0;
    int b_perr_alone     = 0;
    logic a_done_prev    = 1'b0;
    logic a_ferr_prev    = 1'b0;
    logic [7:0] a_words[$];

    int base_cnt;

    uart_receiver_if #(.DBIT(8)) bus_a ();
    uart_receiver_if #(.DBIT(8)) bus_b ();

    assign bus_a.rx     = rx_a;
    assign bus_a.s_tick = s_tick;
    assign bus_b.rx     = rx_b;
    assign bus_b.s_tick = s_tick;

    uart_receiver #(.DBIT(8), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    uart_receiver #(.DBIT(8), .SB_TICK(16), .PAR_EN(1), .PAR_ODD(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Free-running 16x baud tick: one clk high in every four.
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 s_tick = 1'b1;
            @(posedge clk);
            #1 s_tick = 1'b0;
        end
    end

    // Pulse observer: counts status pulses, records received words, flags pulses wider than one clk.
    always @(negedge clk) begin
        if (bus_a.rx_done_tick === 1'b1) begin
            a_done_cnt++;
            a_words.push_back(bus_a.rx_dout);
        end
        if (bus_a.frame_err === 1'b1) a_ferr_cnt++;
        if (bus_a.parity_err === 1'b1) a_perr_cnt++;
        if ((bus_a.rx_done_tick === 1'b1 && a_done_prev) ||
            (bus_a.frame_err === 1'b1 && a_ferr_prev)) a_wide++;
        a_done_prev = (bus_a.rx_done_tick === 1'b1);
        a_ferr_prev = (bus_a.frame_err === 1'b1);

        if (bus_b.rx_done_tick === 1'b1) b_done_cnt++;
        if (bus_b.parity_err === 1'b1) begin
            if (bus_b.rx_done_tick === 1'b1) b_perr_with_done++;
            else                            b_perr_alone++;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] get_word(input int idx);
        if (idx >= 0 && idx < a_words.size()) return a_words[idx];
        return 8'hxx;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitTicks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (s_tick !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic applyStimulus(input bit sel_b, input logic level, input int n);
        #1;
        if (sel_b) rx_b = level;
        else       rx_a = level;
        waitTicks(n);
    endtask

    task automatic sendFrame(input bit sel_b, input logic [7:0] data, input bit with_par,
                             input logic par_bit, input logic stop_bit);
        applyStimulus(sel_b, 1'b0, 16);
        for (int i = 0; i < 8; i++) applyStimulus(sel_b, data[i], 16);
        if (with_par) applyStimulus(sel_b, par_bit, 16);
        applyStimulus(sel_b, stop_bit, 16);
    endtask

    initial begin
        $display("[TB] start");

        reset = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset_dout_a", bus_a.rx_dout, 32'h0);
        checkOutput("reset_done_a", bus_a.rx_done_tick, 32'h0);
        checkOutput("reset_perr_a", bus_a.parity_err, 32'h0);
        checkOutput("reset_ferr_a", bus_a.frame_err, 32'h0);
        checkOutput("reset_dout_b", bus_b.rx_dout, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        waitTicks(8);

        // Plain frame 0xA5
        sendFrame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("a5_done_cnt", a_done_cnt, 32'd1);
        checkOutput("a5_dout", bus_a.rx_dout, 32'hA5);
        checkOutput("a5_word", get_word(0), 32'hA5);
        checkOutput("a5_ferr_cnt", a_ferr_cnt, 32'd0);
        checkOutput("a5_perr_cnt", a_perr_cnt, 32'd0);

        // Short low glitch rejected, then 0x3C
        applyStimulus(1'b0, 1'b0, 4);
        applyStimulus(1'b0, 1'b1, 32);
        @(negedge clk);
        checkOutput("glitch_done_cnt", a_done_cnt, 32'd1);
        checkOutput("glitch_ferr_cnt", a_ferr_cnt, 32'd0);
        checkOutput("glitch_dout", bus_a.rx_dout, 32'hA5);
        sendFrame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("3c_done_cnt", a_done_cnt, 32'd2);
        checkOutput("3c_dout", bus_a.rx_dout, 32'h3C);

        // 0x55 with low stop bit, line held low 40 bit times
        sendFrame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 640);
        @(negedge clk);
        checkOutput("break_ferr_cnt", a_ferr_cnt, 32'd1);
        checkOutput("break_done_cnt", a_done_cnt, 32'd2);
        checkOutput("break_dout_held", bus_a.rx_dout, 32'h3C);
        applyStimulus(1'b0, 1'b1, 32);
        sendFrame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("0f_dout", bus_a.rx_dout, 32'h0F);
        checkOutput("0f_done_cnt", a_done_cnt, 32'd3);
        checkOutput("0f_ferr_cnt", a_ferr_cnt, 32'd1);

        // Even parity on instance B: 0x07 has three ones, so parity bit 1 is correct
        sendFrame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("par_ok_done_cnt", b_done_cnt, 32'd1);
        checkOutput("par_ok_perr", b_perr_with_done, 32'd0);
        checkOutput("par_ok_dout", bus_b.rx_dout, 32'h07);
        sendFrame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("par_bad_done_cnt", b_done_cnt, 32'd2);
        checkOutput("par_bad_perr_with_done", b_perr_with_done, 32'd1);
        checkOutput("par_bad_perr_alone", b_perr_alone, 32'd0);
        checkOutput("par_bad_dout", bus_b.rx_dout, 32'h07);

        // Back-to-back frames with no idle gap
        base_cnt = a_done_cnt;
        sendFrame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        sendFrame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
        sendFrame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("b2b_done_cnt", a_done_cnt, base_cnt + 3);
        checkOutput("b2b_word0", get_word(base_cnt), 32'h00);
        checkOutput("b2b_word1", get_word(base_cnt + 1), 32'hFF);
        checkOutput("b2b_word2", get_word(base_cnt + 2), 32'h81);

        // Reset in the middle of data bit 4 of 0xC3 (bits LSB first: 1,1,0,0,0,...)
        base_cnt = a_done_cnt;
        applyStimulus(1'b0, 1'b0, 16);
        applyStimulus(1'b0, 1'b1, 16);
        applyStimulus(1'b0, 1'b1, 16);
        applyStimulus(1'b0, 1'b0, 16);
        applyStimulus(1'b0, 1'b0, 16);
        applyStimulus(1'b0, 1'b0, 8);
        #1;
        reset = 1'b1;
        rx_a  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midreset_dout", bus_a.rx_dout, 32'h0);
        checkOutput("midreset_done", bus_a.rx_done_tick, 32'h0);
        checkOutput("midreset_perr", bus_a.parity_err, 32'h0);
        checkOutput("midreset_ferr", bus_a.frame_err, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 32);
        @(negedge clk);
        checkOutput("midreset_done_cnt", a_done_cnt, base_cnt);
        checkOutput("midreset_dout_after", bus_a.rx_dout, 32'h0);
        sendFrame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("12_dout", bus_a.rx_dout, 32'h12);
        checkOutput("12_done_cnt", a_done_cnt, base_cnt + 1);

        // Pulse hygiene over the whole run
        checkOutput("pulse_width", a_wide, 32'd0);
        checkOutput("no_parity_pulse_a", a_perr_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter DBIT, default 8: number of data bits per frame, LSB first.
REQ-002 Parameter SB_TICK, default 16: oversampling ticks in the stop bit (16 = 1 stop bit, 24 = 1.5 stop bits, 32 = 2 stop bits).
REQ-003 Parameter PAR_EN, default 0: 1 = one parity bit follows the data bits.
REQ-004 Parameter PAR_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PAR_EN=0.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 rx  input  1  serial line; asynchronous to clk; idles high.
REQ-008 s_tick  input  1  one-clk enable pulse at 16x the baud rate (shared baud generator).
REQ-009 rx_dout  output  DBIT  last correctly framed data word.
REQ-010 rx_done_tick  output  1  one-clk pulse when rx_dout is updated.
REQ-011 parity_err  output  1  one-clk pulse, coincident with rx_done_tick, on parity mismatch.
REQ-012 frame_err  output  1  one-clk pulse when the stop bit is sampled low.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use; FSM logic sees only rx_sync.
REQ-014 Counters SHALL be s (4 bits, or wide enough for SB_TICK-1), n ($clog2(DBIT) bits) and a DBIT-bit shift register b; s advances only on cycles with s_tick=1.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP, BREAK; state and counters registered, next-state logic combinational.
REQ-016 IDLE: if rx_sync=0 -> START, s=0 (does not wait for s_tick).
REQ-017 START: on s_tick with s=7 (mid start bit): if rx_sync=0 -> DATA, s=0, n=0; else -> IDLE with no output pulse (glitch reject); otherwise s++.
REQ-018 DATA: on s_tick with s=15: s=0, b={rx_sync, b[DBIT-1:1]}; if n=DBIT-1 -> PARITY when PAR_EN=1, else STOP; otherwise n++.
REQ-019 PARITY: on s_tick with s=15: s=0, capture p_err = rx_sync XOR (^b) XOR PAR_ODD, -> STOP.
REQ-020 STOP: on s_tick with s=SB_TICK-1: if rx_sync=1 -> rx_dout<=b, rx_done_tick=1, parity_err=p_err AND PAR_EN, -> IDLE.
REQ-021 STOP: if rx_sync=0 at that sample -> frame_err=1, rx_dout unchanged, no rx_done_tick, -> BREAK.
REQ-022 BREAK: remain until rx_sync=1, then -> IDLE (a held-low line yields exactly one frame_err).
REQ-023 rx_done_tick, parity_err and frame_err SHALL be registered, high for exactly one clk, in the clk after the deciding s_tick.
REQ-024 rx_dout SHALL hold its value between frames and change only with rx_done_tick.
REQ-025 Frames SHALL be accepted back-to-back: IDLE reached at the stop sample, so a start edge in the next clk is detected.
REQ-026 Illegal state encodings SHALL return to IDLE on the next clk.

Reset
REQ-027 While reset=1: state=IDLE, s=0, n=0, b=0, p_err=0, sync flops=1, rx_dout=0, rx_done_tick=0, parity_err=0, frame_err=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception restarts at the next falling edge of rx_sync.

Verification
REQ-029 Defaults, frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 ticks/bit -> one rx_done_tick, rx_dout=0xA5, parity_err=0, frame_err=0.
REQ-030 rx low for 4 s_ticks then high -> no pulse on any output, FSM back in IDLE, then frame 0x3C received correctly.
REQ-031 Frame 0x55 with stop bit forced low, rx held low 40 bit times -> exactly one frame_err, rx_dout keeps prior value, next frame 0x0F -> rx_dout=0x0F.
REQ-032 PAR_EN=1, PAR_ODD=0: 0x07 with parity 1 -> parity_err=0; with parity 0 -> parity_err=1 coincident with rx_done_tick, rx_dout=0x07.
REQ-033 Frames 0x00, 0xFF, 0x81 back-to-back with no idle gap -> three rx_done_ticks in order, correct values.
REQ-034 reset pulsed during data bit 4 of 0xC3 -> no rx_done_tick, all outputs 0; following frame 0x12 -> rx_dout=0x12.
